dotprod_operand_fetch: RTL and testbench
========================================

// Module: dotprod_operand_fetch
// PURPOSE
//   Upstream operand streamer for the dot-product datapath. On start, reads vectors A and B
//   element by element from one shared single-port word memory, alternating A[i] and B[i].
//   Presents each {A[i],B[i]} pair on a valid/ready stream. A 2-entry pair FIFO absorbs
//   backpressure. The consumer sees one pair per handshake and never drives memory addresses.
// PARAMETERS
//   DATA_W  32  element / memory word width
//   ADDR_W  32  word-address width; addresses wrap modulo 2^ADDR_W
//   LEN_W   15  vector-length width (matches datapath element counter)
// PORTS
//   clk        in   1       clock
//   rst_n      in   1       reset, asynchronous, active-low
//   start      in   1       1-cycle pulse; sampled only in IDLE
//   a_base     in   ADDR_W  word address of A[0]; captured on accepted start
//   b_base     in   ADDR_W  word address of B[0]; captured on accepted start
//   len        in   LEN_W   element count; captured on accepted start
//   busy       out  1       high from accepted start until the done pulse, inclusive
//   done       out  1       1-cycle pulse at end of the vector
//   mem_en     out  1       memory read enable
//   mem_addr   out  ADDR_W  memory read word address
//   mem_rdata  in   DATA_W  read data, valid exactly 1 cycle after mem_en (fixed latency)
//   out_valid  out  1       pair available
//   out_ready  in   1       consumer accepts pair when out_valid && out_ready
//   out_a      out  DATA_W  A[i]
//   out_b      out  DATA_W  B[i]
//   out_last   out  1       qualifies final pair (i == len-1)
// BEHAVIOUR
//   Reset: FSM=IDLE, counters 0, FIFO empty. All outputs 0: busy, done, mem_en, mem_addr,
//     out_valid, out_a, out_b, out_last. Reset mid-operation abandons the vector; no done.
//   FSM: IDLE -> ISSUE_A -> ISSUE_B -> (ISSUE_A | WAIT_CR | DRAIN) -> IDLE.
//   IDLE: start=1 captures bases and len, sets busy, and clears i.
//     len==0: go to DRAIN and pulse done on the next cycle; no mem_en ever.
//     len!=0: go to ISSUE_A.
//   ISSUE_A: only entered with credit (FIFO count + pairs in flight < 2).
//     Drives mem_en=1, mem_addr=a_base+i.
//   ISSUE_B: drives mem_en=1, mem_addr=b_base+i. Same cycle: A data is registered.
//   Next cycle: B data is registered and the pair {A,B,last} is pushed into the FIFO.
//     Same cycle: i++. Go to ISSUE_A if credit, WAIT_CR if no credit, DRAIN if i==len.
//   WAIT_CR: mem_en=0 until credit frees, then ISSUE_A.
//   DRAIN: wait for FIFO empty, pulse done for 1 cycle, return to IDLE.
//     done is asserted the cycle after the last-pair handshake.
//   Throughput: 1 pair per 2 cycles (memory-bound).
//   Latency: with out_ready=1, first out_valid is 3 cycles after the start edge.
//   FIFO: 2 entries; out_* driven from the head register. Push and pop in the same cycle
//     are both honoured. out_* hold stable while out_valid && !out_ready.
//   Arithmetic: a_base+i and b_base+i are computed in ADDR_W bits and wrap silently.
//     i is LEN_W bits; len up to 2^LEN_W-1.
//   start while busy is ignored and does not alter captured operands.
//   mem_en=0 in every state except ISSUE_A and ISSUE_B; mem_addr holds its last value.
// STRUCTURE
//   Shared package dotprod_pkg: state enum (IDLE, ISSUE_A, ISSUE_B, WAIT_CR, DRAIN),
//     DATA_W/ADDR_W/LEN_W defaults, pair struct {a, b, last}.
//   One sub-module: dotprod_pair_fifo, a 2-deep valid/ready FIFO with count output,
//     used for the credit check.
// TESTING
//   1. mem[x]=x, a_base=0x10, b_base=0x40, len=3, out_ready=1
//      -> pairs (0x10,0x40), (0x11,0x41), (0x12,0x42); out_last on 3rd only;
//         exactly 6 mem_en cycles; done 1 cycle after 3rd handshake.
//   2. len=0 -> done pulses 2 cycles after start; mem_en never 1; out_valid never 1.
//   3. len=5, out_ready=0 for 20 cycles, then 1 -> mem_en stops with FIFO full (2 pairs);
//      all 5 pairs delivered in order, none lost or duplicated.
//   4. a_base=0xFFFF_FFFF, b_base=0x0, len=2 -> mem_addr sequence FFFF_FFFF, 0, 0, 1.
//   5. Assert rst_n low after 2nd pair of len=6 -> all outputs 0 next cycle, no done;
//      a new start with len=1 then completes normally.
//   6. start pulsed again mid-vector with other bases and len -> ignored;
//      original vector completes unchanged.

Source files
------------

// File: rtl/dotprod_pkg.sv
// Shared types and constants for the dot-product operand fetch path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   DEF_DATA_W / DEF_ADDR_W / DEF_LEN_W  default widths for the fetch block
//   state_t + ST_* constants             operand-fetch FSM encoding
//   pair_t                               one {a, b, last} operand pair at default widths
package dotprod_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_LEN_W  = 15;

  typedef logic [2:0] state_t;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ISSUE_A = 3'd1;
  localparam logic [2:0] ST_ISSUE_B = 3'd2;
  localparam logic [2:0] ST_WAIT_CR = 3'd3;
  localparam logic [2:0] ST_DRAIN   = 3'd4;

  typedef struct packed {
    logic [DEF_DATA_W-1:0] a;
    logic [DEF_DATA_W-1:0] b;
    logic                  last;
  } pair_t;

endpackage

// File: rtl/dotprod_pair_fifo.sv
// Two-entry pair FIFO; the head register drives the consumer directly.
// Latency: a pushed word is visible on pop_dat the cycle after the push.
// Backpressure: pop side is valid/ready; push side has no ready, the writer must hold credit.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   push_vld    write push_dat this cycle (ignored when full and not popping)
//   push_dat    word to store
//   pop_vld     head entry is valid
//   pop_rdy     consumer takes the head entry when pop_vld && pop_rdy
//   pop_dat     head entry (held stable while not popped)
//   count       number of stored entries, 0..2
module dotprod_pair_fifo #(
  parameter int WIDTH = 65
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  output logic             pop_vld,
  input  logic             pop_rdy,
  output logic [WIDTH-1:0] pop_dat,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] tail;
  logic [1:0]       cnt;
  logic             pop;
  logic             push;

  assign pop_vld = (cnt != 2'd0);
  assign pop     = pop_vld & pop_rdy;
  // A full FIFO can only accept a word if the head leaves in the same cycle.
  assign push    = push_vld & ((cnt != 2'd2) | pop);
  assign pop_dat = head;
  assign count   = cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      cnt  <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) head <= push_dat;
          else             tail <= push_dat;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          head <= tail;
          cnt  <= cnt - 2'd1;
        end
        2'b11: begin
          // Occupancy is unchanged; the new word lands behind whatever survives.
          if (cnt == 2'd1) begin
            head <= push_dat;
          end else begin
            head <= tail;
            tail <= push_dat;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/dotprod_operand_fetch.sv
// Streams {A[i],B[i]} pairs from one shared single-port word memory to the dot-product datapath.
// Latency: first out_valid 3 cycles after the accepted start edge; one pair per 2 cycles after.
// Backpressure: out_ready low fills the 2-entry pair FIFO, then memory reads stop until credit.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   start              1-cycle request; accepted only when idle (busy low)
//   a_base, b_base     word addresses of A[0] / B[0], captured on accepted start
//   len                element count, captured on accepted start
//   busy               high from accepted start through the done pulse
//   done               1-cycle end-of-vector pulse
//   mem_en, mem_addr   memory read request; rdata returns exactly one cycle later
//   mem_rdata          memory read data
//   out_valid/ready    pair stream handshake
//   out_a, out_b       A[i], B[i]
//   out_last           marks the final pair (i == len-1)
module dotprod_operand_fetch
  import dotprod_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] a_base,
  input  logic [ADDR_W-1:0] b_base,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic              out_last
);

  localparam int PAIR_W = 2 * DATA_W + 1;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] a_base_q;
  logic [ADDR_W-1:0] b_base_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  idx;
  logic [LEN_W-1:0]  idx_inc;
  logic [DATA_W-1:0] a_q;
  logic              last_q;
  logic              b_phase;
  logic              start_ok;

  logic              fifo_vld;
  logic [PAIR_W-1:0] fifo_dat;
  logic [1:0]        fifo_count;
  logic [1:0]        count_nxt;
  logic              pop;
  logic [2:0]        occ;
  logic              credit;

  assign start_ok = start & (state == ST_IDLE) & ~done;
  assign idx_inc  = idx + LEN_W'(1);
  assign pop      = fifo_vld & out_ready;

  // b_phase marks the cycle in which B data arrives; that pair is pushed at its end.
  assign count_nxt = fifo_count + 2'(b_phase) - 2'(pop);

  // Occupancy after this edge counting FIFO entries plus the pair still being fetched.
  // A new pair may be started only if that total leaves room for it.
  assign occ    = 3'(count_nxt) + 3'(state == ST_ISSUE_B);
  assign credit = (occ < 3'd2);

  assign mem_en = (state == ST_ISSUE_A) | (state == ST_ISSUE_B);
  assign busy   = (state != ST_IDLE) | done;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start_ok) state_nxt = (len == '0) ? ST_DRAIN : ST_ISSUE_A;
      end
      ST_ISSUE_A: state_nxt = ST_ISSUE_B;
      ST_ISSUE_B: begin
        if (idx_inc == len_q) state_nxt = ST_DRAIN;
        else if (credit)      state_nxt = ST_ISSUE_A;
        else                  state_nxt = ST_WAIT_CR;
      end
      ST_WAIT_CR: begin
        if (credit) state_nxt = ST_ISSUE_A;
      end
      ST_DRAIN: begin
        // Leave once the last pair has been both pushed and handed over.
        if (count_nxt == 2'd0) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      a_base_q <= '0;
      b_base_q <= '0;
      len_q    <= '0;
      idx      <= '0;
      a_q      <= '0;
      last_q   <= 1'b0;
      b_phase  <= 1'b0;
      done     <= 1'b0;
      mem_addr <= '0;
    end else begin
      state   <= state_nxt;
      b_phase <= (state == ST_ISSUE_B);
      done    <= (state == ST_DRAIN) & (state_nxt == ST_IDLE);
      case (state)
        ST_IDLE: begin
          if (start_ok) begin
            a_base_q <= a_base;
            b_base_q <= b_base;
            len_q    <= len;
            idx      <= '0;
            if (len != '0) mem_addr <= a_base;
          end
        end
        ST_ISSUE_A: begin
          mem_addr <= b_base_q + ADDR_W'(idx);
        end
        ST_ISSUE_B: begin
          // A data is on mem_rdata now; B arrives next cycle and goes straight into the FIFO.
          a_q    <= mem_rdata;
          last_q <= (idx_inc == len_q);
          idx    <= idx_inc;
          if (state_nxt == ST_ISSUE_A) mem_addr <= a_base_q + ADDR_W'(idx_inc);
        end
        ST_WAIT_CR: begin
          if (state_nxt == ST_ISSUE_A) mem_addr <= a_base_q + ADDR_W'(idx);
        end
        default: ;
      endcase
    end
  end

  dotprod_pair_fifo #(
    .WIDTH (PAIR_W)
  ) u_pair_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_vld (b_phase),
    .push_dat ({a_q, mem_rdata, last_q}),
    .pop_vld  (fifo_vld),
    .pop_rdy  (out_ready),
    .pop_dat  (fifo_dat),
    .count    (fifo_count)
  );

  assign out_valid = fifo_vld;
  assign out_a     = fifo_dat[PAIR_W-1 -: DATA_W];
  assign out_b     = fifo_dat[DATA_W:1];
  assign out_last  = fifo_dat[0];

endmodule

// File: tb/tb_dotprod_operand_fetch.sv
module tb_dotprod_operand_fetch;
  import dotprod_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] a_base;
  logic [31:0] b_base;
  logic [14:0] len;
  logic        busy;
  logic        done;
  logic        mem_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic        out_last;

  always #5 clk = ~clk;

  dotprod_operand_fetch dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a_base    (a_base),
    .b_base    (b_base),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .mem_en    (mem_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_last  (out_last)
  );

  // Memory contents: word x holds x ^ salt.
  logic [31:0] salt = 32'h0;
  always @(posedge clk) if (mem_en) mem_rdata <= mem_addr ^ salt;

  int n_vec = 0;
  int n_err = 0;

  // Passive monitor, sampled on the falling edge.
  int          cyc = 0;
  int          mem_en_cnt = 0;
  int          vld_cnt = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          last_hs_cyc = 0;
  int          first_vld_cyc = -1;
  int          start_cyc = 0;
  int          hold_err = 0;
  int          busy_err = 0;
  logic [31:0] addr_q[$];
  pair_t       got_q[$];
  pair_t       prev_pair;
  pair_t       cur_pair;
  logic        prev_stall = 1'b0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    cur_pair = '{a: out_a, b: out_b, last: out_last};
    if (start && !busy && rst_n) start_cyc = cyc;
    if (mem_en) begin
      mem_en_cnt++;
      addr_q.push_back(mem_addr);
    end
    if (out_valid) begin
      vld_cnt++;
      if (first_vld_cyc < 0) first_vld_cyc = cyc;
    end
    if (out_valid && out_ready) begin
      got_q.push_back(cur_pair);
      last_hs_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      if (!busy) busy_err++;
    end
    if (prev_stall && rst_n && (!out_valid || cur_pair !== prev_pair)) hold_err++;
    prev_stall = out_valid && !out_ready && rst_n;
    prev_pair  = cur_pair;
  end

  // Reference: pair i of a vector is (mem[a_base+i], mem[b_base+i], i==len-1).
  function automatic pair_t exp_pair(logic [31:0] ab, logic [31:0] bb, int l, int i);
    pair_t p;
    p.a    = (ab + 32'(i)) ^ salt;
    p.b    = (bb + 32'(i)) ^ salt;
    p.last = (i == l - 1);
    return p;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    mem_en_cnt = 0; vld_cnt = 0; done_cnt = 0; hold_err = 0; busy_err = 0;
    first_vld_cyc = -1;
    addr_q.delete();
    got_q.delete();
  endtask

  task automatic do_start(input logic [31:0] ab, input logic [31:0] bb, input int l);
    a_base = ab; b_base = bb; len = 15'(l); start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Runs until a done pulse; out_ready high with probability pct percent each cycle.
  task automatic wait_done(input int budget, input int pct, output bit ok);
    int n = 0;
    int d0 = done_cnt;
    while (done_cnt == d0 && n < budget) begin
      out_ready = ($urandom_range(99) < pct);
      step();
      n++;
    end
    out_ready = 1'b1;
    ok = (done_cnt != d0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; out_ready = 1'b1;
    a_base = '0; b_base = '0; len = '0;
    repeat (3) step();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b need 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b need 0", done); end
    n_vec++; if (mem_en !== 1'b0) begin n_err++; $display("FAIL reset_mem_en: got %b need 0", mem_en); end
    n_vec++; if (mem_addr !== 32'h0) begin n_err++; $display("FAIL reset_mem_addr: got %h need 0", mem_addr); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b need 0", out_valid); end
    n_vec++; if ({out_a, out_b, out_last} !== 65'h0) begin
      n_err++; $display("FAIL reset_out_data: got %h %h %b need 0", out_a, out_b, out_last);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    bit ok;
    salt = 32'h0;
    clear_mon();
    do_start(32'h10, 32'h40, 3);
    wait_done(100, 100, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL basic_done_timeout: got none need 1 done"); end
    n_vec++; if (got_q.size() != 3) begin n_err++; $display("FAIL basic_count: got %0d need 3", got_q.size()); end
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (i >= got_q.size() || got_q[i] !== exp_pair(32'h10, 32'h40, 3, i)) begin
        n_err++; $display("FAIL basic_pair%0d: got %h need %h", i, (i < got_q.size()) ? got_q[i] : '0, exp_pair(32'h10, 32'h40, 3, i));
      end
    end
    n_vec++; if (mem_en_cnt != 6) begin n_err++; $display("FAIL basic_mem_en_cycles: got %0d need 6", mem_en_cnt); end
    n_vec++; if (done_cyc != last_hs_cyc + 1) begin
      n_err++; $display("FAIL basic_done_timing: got %0d need %0d", done_cyc, last_hs_cyc + 1);
    end
    n_vec++; if (first_vld_cyc - start_cyc != 4) begin
      n_err++; $display("FAIL basic_first_valid_latency: got %0d need 4", first_vld_cyc - start_cyc);
    end
    n_vec++; if (busy_err != 0 || busy !== 1'b0) begin
      n_err++; $display("FAIL basic_busy: got err=%0d busy=%b need 0 0", busy_err, busy);
    end
  endtask

  task automatic test_len_zero();
    bit ok;
    clear_mon();
    do_start(32'h1234, 32'h5678, 0);
    wait_done(20, 100, ok);
    n_vec++; if (!ok || done_cyc - start_cyc != 2) begin
      n_err++; $display("FAIL len0_done_timing: got ok=%0d delta=%0d need 1 2", ok, done_cyc - start_cyc);
    end
    n_vec++; if (mem_en_cnt != 0) begin n_err++; $display("FAIL len0_mem_en: got %0d need 0", mem_en_cnt); end
    n_vec++; if (vld_cnt != 0) begin n_err++; $display("FAIL len0_out_valid: got %0d need 0", vld_cnt); end
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [31:0] ab, bb;
    ab = $urandom; bb = $urandom; salt = $urandom;
    clear_mon();
    out_ready = 1'b0;
    do_start(ab, bb, 5);
    repeat (20) step();
    n_vec++; if (mem_en_cnt != 4) begin n_err++; $display("FAIL bp_mem_en_stalled: got %0d need 4", mem_en_cnt); end
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid_held: got %b need 1", out_valid); end
    wait_done(200, 100, ok);
    n_vec++; if (!ok || got_q.size() != 5) begin
      n_err++; $display("FAIL bp_count: got ok=%0d n=%0d need 1 5", ok, got_q.size());
    end
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if (i >= got_q.size() || got_q[i] !== exp_pair(ab, bb, 5, i)) begin
        n_err++; $display("FAIL bp_pair%0d: got %h need %h", i, (i < got_q.size()) ? got_q[i] : '0, exp_pair(ab, bb, 5, i));
      end
    end
    n_vec++; if (hold_err != 0) begin n_err++; $display("FAIL bp_hold_stable: got %0d need 0", hold_err); end
  endtask

  task automatic test_wrap();
    bit ok;
    logic [31:0] exp_addr[4];
    exp_addr[0] = 32'hFFFF_FFFF; exp_addr[1] = 32'h0; exp_addr[2] = 32'h0; exp_addr[3] = 32'h1;
    clear_mon();
    do_start(32'hFFFF_FFFF, 32'h0, 2);
    wait_done(100, 100, ok);
    n_vec++; if (!ok || addr_q.size() != 4) begin
      n_err++; $display("FAIL wrap_addr_count: got ok=%0d n=%0d need 1 4", ok, addr_q.size());
    end
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (i >= addr_q.size() || addr_q[i] !== exp_addr[i]) begin
        n_err++; $display("FAIL wrap_addr%0d: got %h need %h", i, (i < addr_q.size()) ? addr_q[i] : 32'hx, exp_addr[i]);
      end
    end
    for (int i = 0; i < 2; i++) begin
      n_vec++;
      if (i >= got_q.size() || got_q[i] !== exp_pair(32'hFFFF_FFFF, 32'h0, 2, i)) begin
        n_err++; $display("FAIL wrap_pair%0d: mismatched data", i);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n = 0;
    int d0;
    clear_mon();
    do_start(32'h300, 32'h700, 6);
    while (got_q.size() < 2 && n < 100) begin step(); n++; end
    n_vec++; if (got_q.size() < 2) begin n_err++; $display("FAIL rstmid_two_pairs: got %0d need 2", got_q.size()); end
    d0 = done_cnt;
    rst_n = 1'b0;
    @(negedge clk);
    n_vec++; if ({busy, done, mem_en, out_valid, out_last, mem_addr, out_a, out_b} !== '0) begin
      n_err++; $display("FAIL rstmid_outputs: got busy=%b en=%b vld=%b addr=%h a=%h b=%h need all 0", busy, mem_en, out_valid, mem_addr, out_a, out_b);
    end
    repeat (3) step();
    rst_n = 1'b1;
    repeat (5) step();
    n_vec++; if (done_cnt != d0) begin n_err++; $display("FAIL rstmid_no_done: got %0d need %0d", done_cnt, d0); end
    clear_mon();
    do_start(32'h500, 32'h600, 1);
    wait_done(50, 100, ok);
    n_vec++; if (!ok || got_q.size() != 1 || got_q[0] !== exp_pair(32'h500, 32'h600, 1, 0)) begin
      n_err++; $display("FAIL rstmid_restart: got ok=%0d n=%0d need 1 1", ok, got_q.size());
    end
  endtask

  task automatic test_start_ignored();
    bit ok;
    salt = 32'hA5A5_0F0F;
    clear_mon();
    do_start(32'h100, 32'h200, 4);
    repeat (3) step();
    do_start(32'h9999, 32'h8888, 7);
    wait_done(100, 100, ok);
    n_vec++; if (!ok || got_q.size() != 4) begin
      n_err++; $display("FAIL ign_count: got ok=%0d n=%0d need 1 4", ok, got_q.size());
    end
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (i >= got_q.size() || got_q[i] !== exp_pair(32'h100, 32'h200, 4, i)) begin
        n_err++; $display("FAIL ign_pair%0d: got %h need %h", i, (i < got_q.size()) ? got_q[i] : '0, exp_pair(32'h100, 32'h200, 4, i));
      end
    end
    repeat (10) step();
    n_vec++; if (done_cnt != 1 || mem_en_cnt != 8) begin
      n_err++; $display("FAIL ign_single_run: got done=%0d en=%0d need 1 8", done_cnt, mem_en_cnt);
    end
  endtask

  task automatic test_random();
    bit ok;
    logic [31:0] ab, bb;
    int l, pct;
    for (int t = 0; t < 8; t++) begin
      ab = $urandom; bb = $urandom; salt = $urandom;
      l = $urandom_range(1, 9); pct = $urandom_range(25, 100);
      clear_mon();
      do_start(ab, bb, l);
      wait_done(500, pct, ok);
      n_vec++; if (!ok || got_q.size() != l) begin
        n_err++; $display("FAIL rand%0d_count: got ok=%0d n=%0d need 1 %0d", t, ok, got_q.size(), l);
      end
      for (int i = 0; i < l; i++) begin
        n_vec++;
        if (i >= got_q.size() || got_q[i] !== exp_pair(ab, bb, l, i)) begin
          n_err++; $display("FAIL rand%0d_pair%0d: got %h need %h", t, i, (i < got_q.size()) ? got_q[i] : '0, exp_pair(ab, bb, l, i));
        end
      end
      n_vec++; if (hold_err != 0 || mem_en_cnt != 2 * l) begin
        n_err++; $display("FAIL rand%0d_hold_en: got hold=%0d en=%0d need 0 %0d", t, hold_err, mem_en_cnt, 2 * l);
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_len_zero();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    test_start_ignored();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
